// File: rtl/ovl_fire_arbiter.sv
// Collects per-source checker fire bits and reports one source at a time over a
// valid/ready port, with round-robin fairness, sticky lost-fire flags and saturating report counters.

module ovl_fire_src #(
    parameter int FIRE_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [FIRE_W-1:0] fire,
    input  logic              grant_hit,
    input  logic              cnt_inc,
    input  logic              clear_cnt,
    output logic [FIRE_W-1:0] pend,
    output logic              overflow,
    output logic [CNT_W-1:0]  cnt
);
    logic [FIRE_W-1:0] fire_g;

    assign fire_g = enable ? fire : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= '0;
            overflow <= 1'b0;
            cnt      <= '0;
        end else begin
            // On grant the old bits move into the report; same-cycle fires start the next batch.
            pend <= grant_hit ? fire_g : (pend | fire_g);
            if (clear_cnt) begin
                overflow <= 1'b0;
                cnt      <= '0;
            end else begin
                if ((|fire_g) && (|pend) && !grant_hit)
                    overflow <= 1'b1;
                if (cnt_inc && (cnt != {CNT_W{1'b1}}))
                    cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module ovl_fire_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int FIRE_W  = 3,
    parameter int CNT_W   = 8,
    localparam int SRC_W  = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [NUM_SRC*FIRE_W-1:0] fire_in,
    input  logic                      clear_cnt,
    output logic                      rpt_valid,
    input  logic                      rpt_ready,
    output logic [SRC_W-1:0]          rpt_src,
    output logic [FIRE_W-1:0]         rpt_fire,
    output logic [NUM_SRC-1:0]        overflow,
    input  logic [SRC_W-1:0]          cnt_sel,
    output logic [CNT_W-1:0]          cnt_value
);
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t                           state;
    logic [SRC_W-1:0]                 last_grant;
    logic [SRC_W-1:0]                 grant;
    logic [SRC_W-1:0]                 cand;
    logic                             grant_vld;
    logic [NUM_SRC-1:0][FIRE_W-1:0]   pend;
    logic [NUM_SRC-1:0][CNT_W-1:0]    cnt;
    logic [NUM_SRC-1:0]               pending;
    logic [NUM_SRC-1:0]               grant_hit;
    logic [NUM_SRC-1:0]               cnt_inc;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign pending[i]   = |pend[i];
        assign grant_hit[i] = (state == IDLE) && grant_vld && (grant == SRC_W'(i));
        assign cnt_inc[i]   = (state == PRESENT) && rpt_ready && (rpt_src == SRC_W'(i));

        ovl_fire_src #(.FIRE_W(FIRE_W), .CNT_W(CNT_W)) u_src (
            .clk       (clk),
            .reset_n   (reset_n),
            .enable    (enable),
            .fire      (fire_in[i*FIRE_W +: FIRE_W]),
            .grant_hit (grant_hit[i]),
            .cnt_inc   (cnt_inc[i]),
            .clear_cnt (clear_cnt),
            .pend      (pend[i]),
            .overflow  (overflow[i]),
            .cnt       (cnt[i])
        );
    end

    // Round-robin scan starting just after the last granted source.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = SRC_W'((int'(last_grant) + k) % NUM_SRC);
            if (!grant_vld && pending[cand]) begin
                grant_vld = 1'b1;
                grant     = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rpt_valid  <= 1'b0;
            rpt_src    <= '0;
            rpt_fire   <= '0;
            last_grant <= SRC_W'(NUM_SRC - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        rpt_src    <= grant;
                        rpt_fire   <= pend[grant];
                        last_grant <= grant;
                        rpt_valid  <= 1'b1;
                        state      <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cnt_value = (int'(cnt_sel) < NUM_SRC) ? cnt[cnt_sel] : '0;
endmodule

// File: tb/tb_ovl_fire_arbiter.sv
// Bench for ovl_fire_arbiter: directed vector table, hand sequences for reset,
// saturation and enable gating, then randomized traffic against a behavioural model.

module tb_ovl_fire_arbiter;
    localparam int NS = 4;
    localparam int FW = 3;
    localparam int CW = 2;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic             clear_cnt = 1'b0;
    logic             rpt_ready = 1'b0;
    logic [NS*FW-1:0] fire_in = '0;
    logic [1:0]       cnt_sel = '0;
    logic             rpt_valid;
    logic [1:0]       rpt_src;
    logic [FW-1:0]    rpt_fire;
    logic [NS-1:0]    overflow;
    logic [CW-1:0]    cnt_value;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ovl_fire_arbiter #(.NUM_SRC(NS), .FIRE_W(FW), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .fire_in   (fire_in),
        .clear_cnt (clear_cnt),
        .rpt_valid (rpt_valid),
        .rpt_ready (rpt_ready),
        .rpt_src   (rpt_src),
        .rpt_fire  (rpt_fire),
        .overflow  (overflow),
        .cnt_sel   (cnt_sel),
        .cnt_value (cnt_value)
    );

    typedef struct {
        logic             en;
        logic [NS*FW-1:0] fire;
        logic             rdy;
        logic [1:0]       sel;
        logic             exp_v;
        logic [1:0]       exp_src;
        logic [FW-1:0]    exp_fire;
        logic [NS-1:0]    exp_ovf;
        logic [CW-1:0]    exp_cnt;
    } vec_t;

    vec_t tbl[17];

    // behavioural reference: what each source has waiting, who is being shown, what was counted
    int m_pend[NS];
    int m_cnt[NS];
    bit m_ovf[NS];
    bit m_valid;
    int m_src, m_fire, m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        enable = 1'b0; fire_in = '0; rpt_ready = 1'b0; clear_cnt = 1'b0;
        #3 reset_n = 1'b0;
        #4 reset_n = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = 0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
        end
        m_valid = 1'b0; m_src = 0; m_fire = 0; m_last = NS - 1;
    endtask

    task automatic model_edge();
        int old[NS];
        int g, f;
        bit hs;
        g  = -1;
        hs = m_valid && rpt_ready;
        for (int i = 0; i < NS; i++) old[i] = m_pend[i];
        if (!m_valid)
            for (int k = 1; k <= NS; k++)
                if (g < 0 && old[(m_last + k) % NS] != 0) g = (m_last + k) % NS;
        for (int i = 0; i < NS; i++) begin
            f = enable ? int'(fire_in[i*FW +: FW]) : 0;
            if (f != 0 && old[i] != 0 && i != g) m_ovf[i] = 1'b1;
            m_pend[i] = (i == g) ? f : (old[i] | f);
        end
        if (hs && m_cnt[m_src] < (1 << CW) - 1) m_cnt[m_src]++;
        if (clear_cnt)
            for (int i = 0; i < NS; i++) begin m_cnt[i] = 0; m_ovf[i] = 1'b0; end
        if (g >= 0) begin
            m_valid = 1'b1; m_src = g; m_fire = old[g]; m_last = g;
        end else if (hs) begin
            m_valid = 1'b0;
        end
    endtask

    function automatic logic [NS-1:0] model_ovf();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = m_ovf[i];
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time budget exhausted");
        $fatal(1);
    end

    initial begin
        //            en  fire      rdy sel  v  src fire    ovf    cnt
        tbl[0]  = '{1'b1, 12'h209, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000, 4'h0, 2'd0};
        tbl[1]  = '{1'b1, 12'h000, 1'b1, 2'd0, 1'b1, 2'd0, 3'b001, 4'h0, 2'd0};
        tbl[2]  = '{1'b1, 12'h000, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000, 4'h0, 2'd1};
        tbl[3]  = '{1'b1, 12'h000, 1'b1, 2'd1, 1'b1, 2'd1, 3'b001, 4'h0, 2'd0};
        tbl[4]  = '{1'b1, 12'h000, 1'b1, 2'd1, 1'b0, 2'd0, 3'b000, 4'h0, 2'd1};
        tbl[5]  = '{1'b1, 12'h000, 1'b1, 2'd3, 1'b1, 2'd3, 3'b001, 4'h0, 2'd0};
        tbl[6]  = '{1'b1, 12'h000, 1'b1, 2'd3, 1'b0, 2'd0, 3'b000, 4'h0, 2'd1};
        tbl[7]  = '{1'b1, 12'h080, 1'b1, 2'd2, 1'b0, 2'd0, 3'b000, 4'h0, 2'd0};
        tbl[8]  = '{1'b1, 12'h000, 1'b1, 2'd2, 1'b1, 2'd2, 3'b010, 4'h0, 2'd0};
        tbl[9]  = '{1'b1, 12'h000, 1'b1, 2'd2, 1'b0, 2'd0, 3'b000, 4'h0, 2'd1};
        tbl[10] = '{1'b1, 12'h009, 1'b0, 2'd0, 1'b0, 2'd0, 3'b000, 4'h0, 2'd1};
        tbl[11] = '{1'b1, 12'h020, 1'b0, 2'd0, 1'b1, 2'd0, 3'b001, 4'h2, 2'd1};
        tbl[12] = '{1'b1, 12'h000, 1'b0, 2'd0, 1'b1, 2'd0, 3'b001, 4'h2, 2'd1};
        tbl[13] = '{1'b1, 12'h000, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000, 4'h2, 2'd2};
        tbl[14] = '{1'b1, 12'h000, 1'b0, 2'd1, 1'b1, 2'd1, 3'b101, 4'h2, 2'd1};
        tbl[15] = '{1'b1, 12'h000, 1'b0, 2'd1, 1'b1, 2'd1, 3'b101, 4'h2, 2'd1};
        tbl[16] = '{1'b1, 12'h000, 1'b1, 2'd1, 1'b0, 2'd0, 3'b000, 4'h2, 2'd2};

        // reset state
        do_reset();
        tick();
        chk("rst_valid", rpt_valid, 0);
        chk("rst_src", rpt_src, 0);
        chk("rst_fire", rpt_fire, 0);
        chk("rst_ovf", overflow, 0);
        for (int s = 0; s < NS; s++) begin
            cnt_sel = 2'(s); #1;
            chk($sformatf("rst_cnt%0d", s), cnt_value, 0);
        end

        // round robin, single fire, backpressure/overflow
        for (int i = 0; i < 17; i++) begin
            enable = tbl[i].en; fire_in = tbl[i].fire;
            rpt_ready = tbl[i].rdy; cnt_sel = tbl[i].sel;
            tick();
            chk($sformatf("row%0d_valid", i), rpt_valid, tbl[i].exp_v);
            if (tbl[i].exp_v) begin
                chk($sformatf("row%0d_src", i), rpt_src, tbl[i].exp_src);
                chk($sformatf("row%0d_fire", i), rpt_fire, tbl[i].exp_fire);
            end
            chk($sformatf("row%0d_ovf", i), overflow, tbl[i].exp_ovf);
            chk($sformatf("row%0d_cnt", i), cnt_value, tbl[i].exp_cnt);
        end

        // saturation and clear coincident with handshake
        do_reset();
        enable = 1'b1; rpt_ready = 1'b1; cnt_sel = 2'd0;
        for (int r = 1; r <= 5; r++) begin
            fire_in = 12'h001; tick();
            fire_in = 12'h000; tick();
            chk($sformatf("sat_valid%0d", r), rpt_valid, 1);
            tick();
            chk($sformatf("sat_cnt%0d", r), cnt_value, (r > 3) ? 3 : r);
        end
        fire_in = 12'h001; tick();
        fire_in = 12'h000; rpt_ready = 1'b0; tick();
        fire_in = 12'h001; tick();
        fire_in = 12'h002; tick();
        chk("sat_ovf_set", overflow, 4'b0001);
        chk("sat_hold_src", rpt_src, 0);
        fire_in = 12'h000; rpt_ready = 1'b1; clear_cnt = 1'b1; tick();
        clear_cnt = 1'b0;
        chk("clr_cnt", cnt_value, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_valid", rpt_valid, 0);
        tick();
        chk("clr_next_valid", rpt_valid, 1);
        chk("clr_next_fire", rpt_fire, 3'b011);
        tick();
        chk("clr_next_cnt", cnt_value, 1);

        // reset while presenting
        do_reset();
        enable = 1'b1; rpt_ready = 1'b1; cnt_sel = 2'd2;
        fire_in = 12'h080; tick();
        fire_in = 12'h000; tick();
        tick();
        rpt_ready = 1'b0;
        fire_in = 12'h080; tick();
        fire_in = 12'h000; tick();
        chk("mid_valid_pre", rpt_valid, 1);
        fire_in = 12'h200; tick();
        fire_in = 12'h000;
        chk("mid_cnt_pre", cnt_value, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_async_valid", rpt_valid, 0);
        chk("mid_async_src", rpt_src, 0);
        chk("mid_async_fire", rpt_fire, 0);
        chk("mid_async_ovf", overflow, 0);
        chk("mid_async_cnt", cnt_value, 0);
        #2 reset_n = 1'b1;
        tick(); tick();
        chk("mid_pend_wiped", rpt_valid, 0);
        fire_in = 12'h208; tick();
        fire_in = 12'h000; tick();
        chk("mid_restart_valid", rpt_valid, 1);
        chk("mid_restart_src", rpt_src, 1);

        // enable gating
        do_reset();
        enable = 1'b1; rpt_ready = 1'b1;
        fire_in = 12'h080; tick();
        enable = 1'b0; fire_in = 12'hFFF; tick();
        chk("gate_valid", rpt_valid, 1);
        chk("gate_src", rpt_src, 2);
        chk("gate_fire", rpt_fire, 3'b010);
        tick();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("gate_idle%0d", c), rpt_valid, 0);
        end
        chk("gate_ovf", overflow, 0);

        // randomized traffic against the model
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            enable    = ($urandom_range(3) != 0);
            rpt_ready = 1'($urandom_range(1));
            clear_cnt = ($urandom_range(31) == 0);
            cnt_sel   = 2'($urandom_range(NS - 1));
            for (int i = 0; i < NS; i++)
                fire_in[i*FW +: FW] = ($urandom_range(3) == 0) ? 3'($urandom_range(7, 1)) : 3'b000;
            model_edge();
            tick();
            chk("rnd_valid", rpt_valid, m_valid);
            if (m_valid) begin
                chk("rnd_src", rpt_src, m_src);
                chk("rnd_fire", rpt_fire, m_fire);
            end
            chk("rnd_ovf", overflow, model_ovf());
            chk("rnd_cnt", cnt_value, m_cnt[cnt_sel]);
        end
        clear_cnt = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ovl_fire_arbiter.md
OVL_FIRE_ARBITER -- requirements
Module: ovl_fire_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of checker sources (2..16).
REQ-002 Parameter FIRE_W, default 3: fire vector width per source.
REQ-003 Parameter CNT_W, default 8: per-source report counter width.
REQ-004 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n  input  1  asynchronous active-low reset.
REQ-006 Port enable  input  1  high = capture fire_in; low = ignore fire_in.
REQ-007 Port fire_in  input  NUM_SRC*FIRE_W  source i fire bits at [i*FIRE_W +: FIRE_W].
REQ-008 Port clear_cnt  input  1  synchronous clear of counters and overflow flags.
REQ-009 Port rpt_valid  output  1  report available.
REQ-010 Port rpt_ready  input  1  consumer accepts report.
REQ-011 Port rpt_src  output  clog2(NUM_SRC)  index of reported source.
REQ-012 Port rpt_fire  output  FIRE_W  accumulated fire bits of reported source.
REQ-013 Port overflow  output  NUM_SRC  sticky per-source lost-fire flag.
REQ-014 Port cnt_sel  input  clog2(NUM_SRC)  counter read select.
REQ-015 Port cnt_value  output  CNT_W  combinational read of counter[cnt_sel].

Function
REQ-016 Per-source pending register pend[i] (FIRE_W bits) SHALL OR-accumulate fire_in slice i each cycle enable=1.
REQ-017 Source i is "pending" when pend[i] != 0.
REQ-018 FSM states: IDLE, PRESENT; reset state IDLE.
REQ-019 IDLE, no source pending: stay IDLE, rpt_valid=0.
REQ-020 IDLE, any pending: grant first pending source scanning round-robin from last_grant+1 (mod NUM_SRC); load rpt_src=grant, rpt_fire=pend[grant]; clear pend[grant]; update last_grant; go PRESENT.
REQ-021 PRESENT: rpt_valid=1; rpt_src and rpt_fire SHALL remain stable until handshake.
REQ-022 Handshake = rpt_valid & rpt_ready at a rising edge; on it, increment counter[rpt_src] and return to IDLE.
REQ-023 Maximum throughput is one report per two cycles (mandatory IDLE bubble).
REQ-024 Fire on granted source in the grant cycle SHALL be kept in pend (clear-then-OR: pend[grant] <= fire_in slice), not lost.
REQ-025 overflow[i] SHALL set when enable=1, fire_in slice i != 0 and pend[i] != 0 and i is not being granted that cycle.
REQ-026 Counters SHALL saturate at 2^CNT_W-1; no wrap.
REQ-027 clear_cnt=1 SHALL zero all counters and overflow flags next edge; clear wins over a simultaneous increment or overflow set.
REQ-028 clear_cnt SHALL NOT affect pend, FSM, or report outputs.
REQ-029 enable=0 SHALL NOT stop arbitration or reporting of already-pending fires.
REQ-030 last_grant reset value NUM_SRC-1, so first grant search starts at source 0.
REQ-031 rpt_ready while rpt_valid=0 SHALL have no effect.

Reset
REQ-032 reset_n=0 SHALL immediately (asynchronously) force: FSM=IDLE, rpt_valid=0, rpt_src=0, rpt_fire=0, pend=0, counters=0, overflow=0, last_grant=NUM_SRC-1.
REQ-033 Reset asserted in PRESENT SHALL drop the in-flight report without counting it.
REQ-034 First arbitration after reset deassertion SHALL occur on the first rising edge with reset_n=1.

Verification
REQ-035 Single fire: enable=1, source 2 fires 3'b010 one cycle, rpt_ready=1 -> rpt_valid two edges later with rpt_src=2, rpt_fire=3'b010; cnt_value(sel=2)=1 after handshake.
REQ-036 Round robin: sources 0,1,3 fire same cycle, rpt_ready=1 -> reports in order 0,1,3 on alternate cycles; all counters 1, overflow=0.
REQ-037 Backpressure/overflow: rpt_ready=0, source 1 fires 3'b001 then 3'b100 while pending but not granted -> later report rpt_fire=3'b101 held stable until ready; overflow[1]=1.
REQ-038 Saturation/clear: CNT_W=2, source 0 reported 5 times -> cnt_value=3; clear_cnt coincident with 6th handshake -> cnt_value=0, overflow=0.
REQ-039 Reset mid-report: assert reset_n=0 in PRESENT with rpt_ready=0 -> rpt_valid=0 same cycle without waiting for clk, counters 0, next fire restarts at source 0.
REQ-040 Enable gating: enable=0 with fire_in all ones -> no rpt_valid; pending fires from before enable fell still reported.
